cpe_psum_merger: RTL and testbench

//  Column-bottom merge stage downstream of the last compensation PE in a column.

---
 rtl/cpe_psum_merger_if.sv | 32 +++
 rtl/cpe_psum_merger.sv | 97 +++++++++
 tb/tb_cpe_psum_merger.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/cpe_psum_merger_if.sv
// Stream bundle for the column-bottom partial-sum merger: main/comp inputs,
// result FIFO head with valid/ready, occupancy and sticky error flags.
interface cpe_psum_merger_if #(
    parameter int unsigned PSUM_W = 33,
    parameter int unsigned OUT_W  = 34,
    parameter int unsigned DEPTH  = 8
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [PSUM_W-1:0] main_psum;
    logic              main_valid;
    logic [PSUM_W-1:0] comp_psum;
    logic              comp_valid;
    logic              err_clr;
    logic [OUT_W-1:0]  out_data;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;
    logic [CW-1:0]     fifo_count;
    logic              overflow;
    logic              misalign;

    modport master (
        output main_psum, main_valid, comp_psum, comp_valid, err_clr, out_ready,
        input  out_data, out_last, out_valid, fifo_count, overflow, misalign
    );

    modport slave (
        input  main_psum, main_valid, comp_psum, comp_valid, err_clr, out_ready,
        output out_data, out_last, out_valid, fifo_count, overflow, misalign
    );
endinterface

// File: rtl/cpe_psum_merger.sv
// Delay-aligns main and compensation partial sums, adds them, tags tile ends and
// queues results in a FIFO. Define CPE_MERGE_SAT_EN to clamp sums to 2^PSUM_W-1.
module cpe_psum_merger #(
    parameter int unsigned PSUM_W = 33,
    parameter int unsigned OUT_W  = 34,
    parameter int unsigned DELAY  = 2,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ROWS   = 8
) (
    input logic               clk,
    input logic               rst,
    cpe_psum_merger_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [PSUM_W-1:0] dl_data_q [DELAY];
    logic [DELAY-1:0]  dl_valid_q;

    logic [OUT_W-1:0]  mem_data_q [DEPTH];
    logic [DEPTH-1:0]  mem_last_q;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     cnt_q;
    logic [TW-1:0]     tile_q;
    logic              overflow_q, misalign_q;

    logic              dmain_valid;
    logic [PSUM_W-1:0] dmain;
    logic [OUT_W-1:0]  sum_full, sum;
    logic              full, empty, pop, pair, push, ovf_set, mis_set, tile_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_valid_q <= '0;
            for (int i = 0; i < DELAY; i++) dl_data_q[i] <= '0;
        end else begin
            dl_valid_q[0] <= bus.main_valid;
            dl_data_q[0]  <= bus.main_psum;
            for (int i = 1; i < DELAY; i++) begin
                dl_valid_q[i] <= dl_valid_q[i-1];
                dl_data_q[i]  <= dl_data_q[i-1];
            end
        end
    end

    always_comb begin
        dmain_valid = dl_valid_q[DELAY-1];
        dmain       = dl_data_q[DELAY-1];
        sum_full    = {1'b0, dmain} + {1'b0, bus.comp_psum};
`ifdef CPE_MERGE_SAT_EN
        sum = sum_full[OUT_W-1] ? {1'b0, {PSUM_W{1'b1}}} : sum_full;
`else
        sum = sum_full;
`endif
        full      = (cnt_q == CW'(DEPTH));
        empty     = (cnt_q == '0);
        pop       = !empty && bus.out_ready;
        pair      = dmain_valid && bus.comp_valid;
        // A full FIFO still takes the push if the head leaves in the same cycle.
        push      = pair && (!full || pop);
        ovf_set   = pair && full && !pop;
        mis_set   = dmain_valid ^ bus.comp_valid;
        tile_last = (tile_q == TW'(ROWS - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_data_q[i] <= '0;
            mem_last_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            tile_q     <= '0;
            overflow_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            if (push) begin
                mem_data_q[wr_ptr_q] <= sum;
                mem_last_q[wr_ptr_q] <= tile_last;
                wr_ptr_q             <= wr_ptr_q + 1'b1;
                tile_q               <= tile_last ? '0 : tile_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q      <= cnt_q + CW'(push) - CW'(pop);
            overflow_q <= ovf_set || (overflow_q && !bus.err_clr);
            misalign_q <= mis_set || (misalign_q && !bus.err_clr);
        end
    end

    assign bus.out_data   = mem_data_q[rd_ptr_q];
    assign bus.out_last   = mem_last_q[rd_ptr_q];
    assign bus.out_valid  = !empty;
    assign bus.fifo_count = cnt_q;
    assign bus.overflow   = overflow_q;
    assign bus.misalign   = misalign_q;
endmodule

// File: tb/tb_cpe_psum_merger.sv
// Directed bench for cpe_psum_merger: table of aligned pairs plus hand sequences
// for latency, overflow, misalignment and mid-operation reset.
module tb_cpe_psum_merger;
    localparam int unsigned N = 9;

    typedef struct {
        logic [32:0] m;
        logic [32:0] c;
        logic [33:0] sum;
        logic        last;
    } vec_t;

    logic clk, rst;
    int   n_vec, n_bad;
    vec_t tbl [N];

    cpe_psum_merger_if #(.PSUM_W(33), .OUT_W(34), .DEPTH(8)) bus ();

    cpe_psum_merger #(
        .PSUM_W(33), .OUT_W(34), .DELAY(2), .DEPTH(8), .ROWS(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.main_psum  = '0;
        bus.main_valid = 1'b0;
        bus.comp_psum  = '0;
        bus.comp_valid = 1'b0;
        bus.err_clr    = 1'b0;
        bus.out_ready  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        tbl[0] = '{33'd100, 33'd5, 34'd105, 1'b0};
        tbl[1] = '{33'd1, 33'd2, 34'd3, 1'b0};
`ifdef CPE_MERGE_SAT_EN
        tbl[2] = '{33'h1_FFFF_FFFF, 33'd1, 34'h1_FFFF_FFFF, 1'b0};
        tbl[4] = '{33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF, 34'h1_FFFF_FFFF, 1'b0};
`else
        tbl[2] = '{33'h1_FFFF_FFFF, 33'd1, 34'h2_0000_0000, 1'b0};
        tbl[4] = '{33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF, 34'h3_FFFF_FFFE, 1'b0};
`endif
        tbl[3] = '{33'd0, 33'd0, 34'd0, 1'b0};
        tbl[5] = '{33'd12345, 33'd67890, 34'd80235, 1'b0};
        tbl[6] = '{33'd7, 33'd8, 34'd15, 1'b0};
        tbl[7] = '{33'd1000, 33'd24, 34'd1024, 1'b1};
        tbl[8] = '{33'd3, 33'd4, 34'd7, 1'b0};

        idle_inputs();
        rst = 1'b1;
        #2;
        chk("reset out_data", 64'(bus.out_data), 64'd0);
        chk("reset out_last", 64'(bus.out_last), 64'd0);
        chk("reset out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset fifo_count", 64'(bus.fifo_count), 64'd0);
        chk("reset overflow", 64'(bus.overflow), 64'd0);
        chk("reset misalign", 64'(bus.misalign), 64'd0);

        // Latency: main at c0, comp at c2, result visible at c3.
        do_reset();
        bus.main_valid = 1'b1; bus.main_psum = 33'd100;
        tick();
        bus.main_valid = 1'b0; bus.main_psum = '0;
        tick();
        bus.comp_valid = 1'b1; bus.comp_psum = 33'd5;
        chk("lat c2 out_valid", 64'(bus.out_valid), 64'd0);
        tick();
        bus.comp_valid = 1'b0;
        chk("lat c3 out_valid", 64'(bus.out_valid), 64'd1);
        chk("lat c3 out_data", 64'(bus.out_data), 64'd105);
        chk("lat c3 out_last", 64'(bus.out_last), 64'd0);

        // Streamed table, consumer always ready.
        do_reset();
        bus.out_ready = 1'b1;
        for (int c = 0; c < N + 3; c++) begin
            bus.main_valid = 1'b0; bus.main_psum = '0;
            bus.comp_valid = 1'b0; bus.comp_psum = '0;
            if (c < N) begin
                bus.main_valid = 1'b1; bus.main_psum = tbl[c].m;
            end
            if (c >= 2 && c - 2 < N) begin
                bus.comp_valid = 1'b1; bus.comp_psum = tbl[c-2].c;
            end
            if (c >= 3) begin
                chk($sformatf("vec%0d out_valid", c - 3), 64'(bus.out_valid), 64'd1);
                chk($sformatf("vec%0d out_data", c - 3), 64'(bus.out_data), 64'(tbl[c-3].sum));
                chk($sformatf("vec%0d out_last", c - 3), 64'(bus.out_last), 64'(tbl[c-3].last));
            end
            tick();
        end
        idle_inputs();
        chk("table drained out_valid", 64'(bus.out_valid), 64'd0);
        chk("table misalign", 64'(bus.misalign), 64'd0);

        // Fill with out_ready=0: 9 pairs, 9th dropped.
        do_reset();
        for (int c = 0; c < 11; c++) begin
            bus.main_valid = (c < 9); bus.main_psum = 33'(10 + c);
            bus.comp_valid = (c >= 2); bus.comp_psum = 33'd1;
            tick();
        end
        idle_inputs();
        chk("full fifo_count", 64'(bus.fifo_count), 64'd8);
        chk("full overflow", 64'(bus.overflow), 64'd1);
        chk("full head", 64'(bus.out_data), 64'd11);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("overflow cleared", 64'(bus.overflow), 64'd0);
        bus.main_valid = 1'b1; bus.main_psum = 33'd50;
        tick();
        bus.main_valid = 1'b0;
        tick();
        bus.comp_valid = 1'b1; bus.comp_psum = 33'd1; bus.out_ready = 1'b1;
        tick();
        idle_inputs();
        chk("push+pop fifo_count", 64'(bus.fifo_count), 64'd8);
        chk("push+pop overflow", 64'(bus.overflow), 64'd0);
        chk("push+pop head", 64'(bus.out_data), 64'd12);

        // Misaligned main/comp; then a set event racing err_clr.
        do_reset();
        bus.main_valid = 1'b1; bus.main_psum = 33'd9;
        tick();
        bus.main_valid = 1'b0; bus.comp_valid = 1'b1; bus.comp_psum = 33'd9;
        tick();
        bus.comp_valid = 1'b0;
        tick();
        chk("misalign set", 64'(bus.misalign), 64'd1);
        chk("misalign no push", 64'(bus.fifo_count), 64'd0);
        chk("misalign out_valid", 64'(bus.out_valid), 64'd0);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("misalign cleared", 64'(bus.misalign), 64'd0);
        bus.main_valid = 1'b1;
        tick();
        bus.main_valid = 1'b0;
        tick();
        bus.err_clr = 1'b1;
        chk("misalign before race", 64'(bus.misalign), 64'd0);
        tick();
        bus.err_clr = 1'b0;
        chk("set wins over clr", 64'(bus.misalign), 64'd1);

        // Reset with 5 queued and 2 in the delay line.
        do_reset();
        for (int c = 0; c < 7; c++) begin
            bus.main_valid = 1'b1; bus.main_psum = 33'(20 + c);
            bus.comp_valid = (c >= 2); bus.comp_psum = 33'd3;
            tick();
        end
        idle_inputs();
        chk("pre-reset fifo_count", 64'(bus.fifo_count), 64'd5);
        rst = 1'b1;
        #1;
        chk("async rst out_valid", 64'(bus.out_valid), 64'd0);
        chk("async rst fifo_count", 64'(bus.fifo_count), 64'd0);
        chk("async rst out_data", 64'(bus.out_data), 64'd0);
        tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("post-rst out_valid", 64'(bus.out_valid), 64'd0);
        chk("post-rst fifo_count", 64'(bus.fifo_count), 64'd0);
        chk("post-rst misalign", 64'(bus.misalign), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
